// File: rtl/alu_seq.sv
// Clocked ALU: single-cycle logic/arithmetic ops plus iterative shifts and a
// shift-add multiply, all sharing one result/flag register.
module alu_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         m,
    input  logic [3:0]   s,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] t,
    output logic         cf,
    output logic         zf,
    output logic         busy,
    output logic         done,
    output logic [1:0]   state_o
);
    localparam int CW   = $clog2(W);
    localparam int CNTW = CW + 1;

    typedef enum logic [1:0] {IDLE, SHL, SHR, MUL} state_t;
    typedef enum logic [1:0] {K_SINGLE, K_SHL, K_SHR, K_MUL} kind_t;

    // Handshake: start is taken on an edge where busy=0 (edge E0); a, b, m, s are
    // captured there. done pulses for one cycle when t/cf/zf have just been written.
    state_t           state_q;
    logic [W-1:0]     t_q;
    logic             cf_q;
    logic             zf_q;
    logic             busy_q;
    logic             done_q;
    logic [W-1:0]     work_q;
    logic [CNTW-1:0]  cnt_q;
    logic [2*W-1:0]   acc_q;
    logic [2*W-1:0]   mcand_q;
    logic [W-1:0]     mplier_q;

    kind_t            op_kind;
    logic [W-1:0]     op_res;
    logic             op_cf;
    logic             op_upd;
    logic [W:0]       sum;
    logic [CW-1:0]    shamt;
    logic [W-1:0]     shift_nxt;
    logic             shift_out;
    logic [2*W-1:0]   acc_nxt;

    assign shamt = b[CW-1:0];

    always_comb begin
        op_kind = K_SINGLE;
        op_res  = '0;
        op_cf   = cf_q;
        op_upd  = 1'b0;
        sum     = '0;
        case ({m, s})
            5'b0_1100: op_res = a;
            5'b1_1010,
            5'b1_0100: op_res = b;
            5'b1_0101: op_res = ~b;
            5'b1_1011: op_res = a & b;
            5'b1_1001: begin
                sum    = {1'b0, a} + {1'b0, b};
                op_res = sum[W-1:0];
                op_cf  = sum[W];
                op_upd = 1'b1;
            end
            5'b1_0110: begin
                sum    = {1'b0, b} - {1'b0, a};
                op_res = sum[W-1:0];
                op_cf  = sum[W];
                op_upd = 1'b1;
            end
            5'b1_0111: begin
                sum    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cf_q};
                op_res = sum[W-1:0];
                op_cf  = sum[W];
                op_upd = 1'b1;
            end
            5'b1_1000: begin
                sum    = {1'b0, b} - {1'b0, a} - {{W{1'b0}}, cf_q};
                op_res = sum[W-1:0];
                op_cf  = sum[W];
                op_upd = 1'b1;
            end
            5'b0_0001,
            5'b0_0010: begin
                // A zero count finishes immediately with the operand unchanged.
                if (shamt == '0) begin
                    op_res = a;
                    op_cf  = 1'b0;
                    op_upd = 1'b1;
                end else begin
                    op_kind = s[0] ? K_SHL : K_SHR;
                end
            end
            5'b0_0011: op_kind = K_MUL;
            default:   op_res = '0;
        endcase
    end

    always_comb begin
        shift_nxt = '0;
        shift_out = 1'b0;
        if (state_q == SHL) begin
            shift_nxt = {work_q[W-2:0], 1'b0};
            shift_out = work_q[W-1];
        end else begin
            shift_nxt = {1'b0, work_q[W-1:1]};
            shift_out = work_q[0];
        end
        acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            t_q      <= '0;
            cf_q     <= 1'b0;
            zf_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            work_q   <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        case (op_kind)
                            K_SINGLE: begin
                                t_q    <= op_res;
                                done_q <= 1'b1;
                                if (op_upd) begin
                                    cf_q <= op_cf;
                                    zf_q <= (op_res == '0);
                                end
                            end
                            K_SHL, K_SHR: begin
                                work_q  <= a;
                                cnt_q   <= {1'b0, shamt};
                                busy_q  <= 1'b1;
                                state_q <= (op_kind == K_SHL) ? SHL : SHR;
                            end
                            default: begin
                                acc_q    <= '0;
                                mcand_q  <= {{W{1'b0}}, a};
                                mplier_q <= b;
                                cnt_q    <= CNTW'(W);
                                busy_q   <= 1'b1;
                                state_q  <= MUL;
                            end
                        endcase
                    end
                end
                SHL, SHR: begin
                    work_q <= shift_nxt;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == CNTW'(1)) begin
                        t_q     <= shift_nxt;
                        cf_q    <= shift_out;
                        zf_q    <= (shift_nxt == '0);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                MUL: begin
                    acc_q    <= acc_nxt;
                    mcand_q  <= {mcand_q[2*W-2:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[W-1:1]};
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == CNTW'(1)) begin
                        t_q     <= acc_nxt[W-1:0];
                        cf_q    <= |acc_nxt[2*W-1:W];
                        zf_q    <= (acc_nxt[W-1:0] == '0);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign t       = t_q;
    assign cf      = cf_q;
    assign zf      = zf_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (W=8): an ordered vector table with hand-computed
// results, plus sequences for the ignored start during a shift and reset mid-multiply.
module tb_alu_seq;
    logic       clk;
    logic       rst;
    logic       start;
    logic       m;
    logic [3:0] s;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] t;
    logic       cf;
    logic       zf;
    logic       busy;
    logic       done;
    logic [1:0] state_o;

    int tests_run = 0;
    int tests_failed = 0;

    alu_seq #(.W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .m(m), .s(s), .a(a), .b(b),
        .t(t), .cf(cf), .zf(zf), .busy(busy), .done(done), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       m;
        logic [3:0] s;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] t;
        logic       cf;
        logic       zf;
        int         lat;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op; returns the edge index after E0 where done was seen (-1 on
    // timeout), the number of busy samples and whether t moved while busy.
    task automatic do_op(input logic om, input logic [3:0] os, input logic [7:0] oa,
                         input logic [7:0] ob, input int inject_at,
                         output int k, output int bc, output bit moved);
        logic [7:0] t_before;
        int j;
        k = -1;
        bc = 0;
        moved = 1'b0;
        @(negedge clk);
        t_before = t;
        m = om; s = os; a = oa; b = ob; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        j = 0;
        while (j <= 40) begin
            if (done) begin
                k = j;
                chk("busy_at_done", {15'd0, busy}, 16'd0);
                break;
            end
            if (busy) bc++;
            if (t !== t_before) moved = 1'b1;
            if (j == inject_at) begin
                @(negedge clk);
                m = 1'b1; s = 4'b1001; a = 8'h11; b = 8'h22; start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            j++;
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int k;
        int bc;
        bit moved;
        do_op(v.m, v.s, v.a, v.b, -1, k, bc, moved);
        chk({tag, "_lat"},  k[15:0], v.lat[15:0]);
        chk({tag, "_busy"}, bc[15:0], v.lat[15:0]);
        chk({tag, "_t"},    {8'd0, t}, {8'd0, v.t});
        chk({tag, "_cf"},   {15'd0, cf}, {15'd0, v.cf});
        chk({tag, "_zf"},   {15'd0, zf}, {15'd0, v.zf});
        chk({tag, "_moved"}, {15'd0, moved}, 16'd0);
    endtask

    initial begin
        int k;
        int bc;
        bit moved;
        vec_t v;

        //          m     s        a      b      t      cf    zf    lat
        vecs[0]  = '{1'b1, 4'b1001, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 0}; // ADD
        vecs[1]  = '{1'b1, 4'b0111, 8'h01, 8'h01, 8'h03, 1'b0, 1'b0, 0}; // ADC
        vecs[2]  = '{1'b1, 4'b0110, 8'h05, 8'h03, 8'hFE, 1'b1, 1'b0, 0}; // SUB
        vecs[3]  = '{1'b1, 4'b1000, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 0}; // SBB
        vecs[4]  = '{1'b0, 4'b0001, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 3}; // SHL
        vecs[5]  = '{1'b0, 4'b0010, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 1}; // SHR
        vecs[6]  = '{1'b0, 4'b0011, 8'h10, 8'h11, 8'h10, 1'b1, 1'b0, 8}; // MUL
        vecs[7]  = '{1'b0, 4'b0011, 8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0, 8}; // MUL
        vecs[8]  = '{1'b1, 4'b0110, 8'h42, 8'h42, 8'h00, 1'b0, 1'b1, 0}; // SUB eq
        vecs[9]  = '{1'b1, 4'b1011, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 0}; // AND
        vecs[10] = '{1'b0, 4'b1100, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b1, 0}; // pass a
        vecs[11] = '{1'b0, 4'b0000, 8'h33, 8'h44, 8'h00, 1'b0, 1'b1, 0}; // undefined
        vecs[12] = '{1'b1, 4'b1010, 8'h00, 8'hC3, 8'hC3, 1'b0, 1'b1, 0}; // pass b
        vecs[13] = '{1'b1, 4'b0100, 8'hAA, 8'h00, 8'h00, 1'b0, 1'b1, 0}; // pass b
        vecs[14] = '{1'b1, 4'b0101, 8'h00, 8'h0F, 8'hF0, 1'b0, 1'b1, 0}; // not b
        vecs[15] = '{1'b0, 4'b0001, 8'h5A, 8'h08, 8'h5A, 1'b0, 1'b0, 0}; // SHL by 0
        vecs[16] = '{1'b0, 4'b0010, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 0}; // SHR by 0
        vecs[17] = '{1'b1, 4'b1001, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 0}; // ADD wrap
        vecs[18] = '{1'b0, 4'b0010, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 7}; // SHR by 7
        vecs[19] = '{1'b0, 4'b0001, 8'hC0, 8'h02, 8'h00, 1'b1, 1'b1, 2}; // SHL out
        vecs[20] = '{1'b1, 4'b0111, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 0}; // ADC cin
        vecs[21] = '{1'b1, 4'b1000, 8'h00, 8'h05, 8'h04, 1'b0, 1'b0, 0}; // SBB bin
        vecs[22] = '{1'b0, 4'b0011, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 8}; // MUL max
        vecs[23] = '{1'b0, 4'b0011, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 8}; // MUL zero

        rst = 1'b1; start = 1'b0; m = 1'b0; s = 4'd0; a = 8'd0; b = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_t",    {8'd0, t}, 16'd0);
        chk("rst_cf",   {15'd0, cf}, 16'd0);
        chk("rst_zf",   {15'd0, zf}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_state", {14'd0, state_o}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Give t a known nonzero value, then shift while a start is pulsed mid-op.
        v = '{1'b1, 4'b1001, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 0};
        run_vec("pre_inj", v);
        do_op(1'b0, 4'b0001, 8'h01, 8'h05, 2, k, bc, moved);
        chk("inj_lat",   k[15:0], 16'd5);
        chk("inj_busy",  bc[15:0], 16'd5);
        chk("inj_moved", {15'd0, moved}, 16'd0);
        chk("inj_t",     {8'd0, t}, 16'h0020);
        chk("inj_cf",    {15'd0, cf}, 16'd0);
        @(posedge clk); #1;
        chk("inj_done_pulse", {15'd0, done}, 16'd0);
        chk("inj_t_after",    {8'd0, t}, 16'h0020);
        chk("inj_busy_after", {15'd0, busy}, 16'd0);

        // Nonzero t and cf, then reset asynchronously after E4 of a multiply.
        v = '{1'b1, 4'b1001, 8'hFF, 8'h21, 8'h20, 1'b1, 1'b0, 0};
        run_vec("pre_rst", v);
        @(negedge clk);
        m = 1'b0; s = 4'b0011; a = 8'h10; b = 8'h11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("mid_busy", {15'd0, busy}, 16'd1);
        rst = 1'b1;
        #1;
        chk("arst_t",     {8'd0, t}, 16'd0);
        chk("arst_cf",    {15'd0, cf}, 16'd0);
        chk("arst_zf",    {15'd0, zf}, 16'd0);
        chk("arst_busy",  {15'd0, busy}, 16'd0);
        chk("arst_done",  {15'd0, done}, 16'd0);
        chk("arst_state", {14'd0, state_o}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        v = '{1'b1, 4'b1001, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 0};
        run_vec("post_rst", v);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
